shim_rr_hdr: RTL

Multi-channel successor to the single-channel shim: merges NCH metadata/packet stream pairs into one AXI-Stream output at packet granularity. A round-robin arbiter grants one channel per packet; the granted channel's metadata beat is optionally emitted as a header beat, followed by that channel's payload beats up to and including TLAST. The block sits between the per-channel pingponger outputs and the single downstream consumer.

---
 rtl/shim_rr_hdr_pkg.sv | 27 ++
 rtl/shim_rr_hdr_rr_arbiter.sv | 50 +++++
 rtl/shim_rr_hdr.sv | 136 +++++++++++++
 3 files changed

// File: rtl/shim_rr_hdr_pkg.sv
// Shared types and helpers for the multi-channel packet shim.
package shim_pkg;

    typedef enum logic {
        IDLE,
        DATA
    } state_t;

    // Widest TKEEP the all-ones helper can build (DW up to 2048).
    localparam int unsigned KEEP_MAX = 256;

    // Channel-index width: clog2 of the channel count, never below one bit.
    function automatic int unsigned chan_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // All-ones byte-enable pattern for nbytes lanes; callers truncate to width.
    function automatic logic [KEEP_MAX-1:0] keep_ones(input int unsigned nbytes);
        logic [KEEP_MAX-1:0] k;
        k = '0;
        for (int unsigned i = 0; i < KEEP_MAX; i++) begin
            if (i < nbytes) k[i] = 1'b1;
        end
        return k;
    endfunction

endpackage

// File: rtl/shim_rr_hdr_rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last granted channel.
module rr_arbiter
    import shim_pkg::*;
#(
    parameter int unsigned N = 2,
    parameter int unsigned W = chan_w(N)
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [W-1:0] ptr;

    // Pointer remembers the last grant; reset makes channel 0 win first.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr <= W'(N - 1);
        end else if (advance && any) begin
            ptr <= idx;
        end
    end

    // First requester found when walking upward from ptr+1, wrapping at N.
    always_comb begin
        int unsigned  c;
        logic [W-1:0] cw;
        logic         found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        cw    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            c  = (32'(ptr) + 32'(i) + 32'd1) % N;
            cw = W'(c);
            if (!found && req[cw]) begin
                found     = 1'b1;
                grant[cw] = 1'b1;
                idx       = cw;
            end
        end
        any = |req;
    end

endmodule

// File: rtl/shim_rr_hdr.sv
// Merges NCH metadata/payload stream pairs into one AXI-Stream output,
// one whole packet per grant, optionally prefixed by a header beat.
module shim_rr_hdr
    import shim_pkg::*;
#(
    parameter int unsigned DW     = 512,
    parameter int unsigned NCH    = 2,
    parameter bit          HDR_EN = 1'b1,
    localparam int unsigned CW    = chan_w(NCH)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NCH*DW-1:0]       AXIS_IN_MD_TDATA,
    input  logic [NCH-1:0]          AXIS_IN_MD_TVALID,
    output logic [NCH-1:0]          AXIS_IN_MD_TREADY,
    input  logic [NCH*DW-1:0]       AXIS_IN_TDATA,
    input  logic [NCH-1:0]          AXIS_IN_TVALID,
    output logic [NCH-1:0]          AXIS_IN_TREADY,
    input  logic [NCH*(DW/8)-1:0]   AXIS_IN_TKEEP,
    input  logic [NCH-1:0]          AXIS_IN_TLAST,
    output logic [DW-1:0]           AXIS_OUT_TDATA,
    output logic                    AXIS_OUT_TVALID,
    input  logic                    AXIS_OUT_TREADY,
    output logic [DW/8-1:0]         AXIS_OUT_TKEEP,
    output logic                    AXIS_OUT_TLAST,
    output logic [CW-1:0]           AXIS_OUT_TDEST
);

    localparam int unsigned      KW       = DW / 8;
    localparam logic [KW-1:0]    KEEP_ALL = KW'(keep_ones(KW));

    state_t          state_q, state_d;
    logic [CW-1:0]   g_q;
    logic [NCH-1:0]  arb_grant;
    logic [CW-1:0]   arb_idx;
    logic            arb_any;
    logic            slot_free;
    logic            md_hs;
    logic            pl_hs;
    logic [DW-1:0]   sel_md;
    logic [DW-1:0]   sel_data;
    logic [KW-1:0]   sel_keep;
    logic            sel_last;
    logic            sel_valid;

    assign slot_free = !AXIS_OUT_TVALID || AXIS_OUT_TREADY;
    assign md_hs     = (state_q == IDLE) && arb_any && slot_free;
    assign pl_hs     = (state_q == DATA) && slot_free && sel_valid;

    rr_arbiter #(
        .N (NCH),
        .W (CW)
    ) u_arb (
        .clk     (clk),
        .resetn  (resetn),
        .req     (AXIS_IN_MD_TVALID),
        .advance (md_hs),
        .grant   (arb_grant),
        .idx     (arb_idx),
        .any     (arb_any)
    );

    // Per-channel muxes: metadata follows the live grant, payload the held one.
    always_comb begin
        sel_md    = '0;
        sel_data  = '0;
        sel_keep  = '0;
        sel_last  = 1'b0;
        sel_valid = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (arb_idx == CW'(i)) sel_md = AXIS_IN_MD_TDATA[i*DW +: DW];
            if (g_q == CW'(i)) begin
                sel_data  = AXIS_IN_TDATA[i*DW +: DW];
                sel_keep  = AXIS_IN_TKEEP[i*KW +: KW];
                sel_last  = AXIS_IN_TLAST[i];
                sel_valid = AXIS_IN_TVALID[i];
            end
        end
    end

    // State register and held grant.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            g_q     <= '0;
        end else begin
            state_q <= state_d;
            if (md_hs) g_q <= arb_idx;
        end
    end

    // Next state: leave IDLE on a metadata handshake, return after TLAST.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (md_hs) state_d = DATA;
            DATA:    if (pl_hs && sel_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Ready outputs: only the granted channel, only in its own phase.
    always_comb begin
        AXIS_IN_MD_TREADY = md_hs ? arb_grant : '0;
        AXIS_IN_TREADY    = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            AXIS_IN_TREADY[i] = (state_q == DATA) && slot_free && (g_q == CW'(i));
        end
    end

    // Single output stage: load header or payload when the slot is free.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            AXIS_OUT_TVALID <= 1'b0;
            AXIS_OUT_TDATA  <= '0;
            AXIS_OUT_TKEEP  <= '0;
            AXIS_OUT_TLAST  <= 1'b0;
            AXIS_OUT_TDEST  <= '0;
        end else if (HDR_EN && md_hs) begin
            AXIS_OUT_TVALID <= 1'b1;
            AXIS_OUT_TDATA  <= sel_md;
            AXIS_OUT_TKEEP  <= KEEP_ALL;
            AXIS_OUT_TLAST  <= 1'b0;
            AXIS_OUT_TDEST  <= arb_idx;
        end else if (pl_hs) begin
            AXIS_OUT_TVALID <= 1'b1;
            AXIS_OUT_TDATA  <= sel_data;
            AXIS_OUT_TKEEP  <= sel_keep;
            AXIS_OUT_TLAST  <= sel_last;
            AXIS_OUT_TDEST  <= g_q;
        end else if (AXIS_OUT_TREADY) begin
            AXIS_OUT_TVALID <= 1'b0;
        end
    end

endmodule
